tpu_array_ctrl: RTL and testbench

Sequencer for a DIM×DIM systolic array of `tpumac` cells. It accepts a start command, then preloads or clears the accumulators row by row, and streams DIM operand beats. It flushes the array skew and drains the results row by row over a valid/ready handshake. It sits between the host command/operand buffers and the array, and drives the array-wide `en`, the per-row `WrEn`, and the operand and result row indices.

---
 rtl/tpu_pkg.sv | 13 +
 rtl/tpu_array_ctrl.sv | 135 +++++++++++++
 tb/tb_tpu_array_ctrl.sv | 298 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/tpu_pkg.sv
// Shared types and helpers for the systolic-array sequencer.
package tpu_pkg;

  typedef enum logic [1:0] {IDLE, LOADC, COMPUTE, DRAIN} tpu_ctrl_state_e;

  localparam int TPU_DIM_DEFAULT = 8;

  // Operand beats plus the skew needed to push the last beat through the array.
  function automatic int compute_cycles(input int dim);
    return 3 * dim - 2;
  endfunction

endpackage

// File: rtl/tpu_array_ctrl.sv
// Sequencer for a DIM x DIM systolic MAC array: preload/clear C, stream
// operand beats, flush the skew, then drain result rows over valid/ready.
module tpu_array_ctrl
  import tpu_pkg::*;
#(
  parameter int DIM  = TPU_DIM_DEFAULT,
  parameter int IDXW = $clog2(DIM),
  parameter int CNTW = $clog2(3 * DIM)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start_i,
  input  logic            load_c_i,
  input  logic            abort_i,
  input  logic            stall_i,
  input  logic            out_ready_i,
  output logic            busy_o,
  output logic            done_o,
  output logic            mac_en_o,
  output logic [DIM-1:0]  c_wr_en_o,
  output logic            c_clear_o,
  output logic            feed_valid_o,
  output logic [IDXW-1:0] k_idx_o,
  output logic            out_valid_o,
  output logic [IDXW-1:0] out_row_o
);

  localparam logic [CNTW-1:0] CNT_ONE   = CNTW'(1);
  localparam logic [CNTW-1:0] LAST_ROW  = CNTW'(DIM - 1);
  localparam logic [CNTW-1:0] FEED_BEAT = CNTW'(DIM);
  localparam logic [CNTW-1:0] COMP_LAST = CNTW'(compute_cycles(DIM) - 1);
  localparam logic [DIM-1:0]  ROW0_SEL  = DIM'(1);

  tpu_ctrl_state_e state_q, state_d;
  logic [CNTW-1:0] cnt_q, cnt_d;
  logic            clr_q, clr_d;
  logic            done_q, done_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      clr_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      clr_q   <= clr_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    clr_d        = clr_q;
    done_d       = 1'b0;
    mac_en_o     = 1'b0;
    c_wr_en_o    = '0;
    c_clear_o    = 1'b0;
    feed_valid_o = 1'b0;
    k_idx_o      = '0;
    out_valid_o  = 1'b0;
    out_row_o    = '0;

    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          clr_d   = !load_c_i;
          cnt_d   = '0;
          state_d = LOADC;
        end
      end

      LOADC: begin
        c_wr_en_o = ROW0_SEL << cnt_q;
        c_clear_o = clr_q;
        if (cnt_q == LAST_ROW) begin
          cnt_d   = '0;
          state_d = COMPUTE;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      COMPUTE: begin
        // The stall gate is the only combinational input-to-output path.
        mac_en_o = !stall_i;
        if (cnt_q < FEED_BEAT) begin
          feed_valid_o = !stall_i;
          k_idx_o      = cnt_q[IDXW-1:0];
        end
        if (!stall_i) begin
          if (cnt_q == COMP_LAST) begin
            cnt_d   = '0;
            state_d = DRAIN;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
      end

      DRAIN: begin
        out_valid_o = 1'b1;
        out_row_o   = cnt_q[IDXW-1:0];
        if (out_ready_i) begin
          if (cnt_q == LAST_ROW) begin
            cnt_d   = '0;
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
      end

      default: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase

    // Abort wins over every transition and suppresses the done pulse.
    if (abort_i) begin
      state_d = IDLE;
      cnt_d   = '0;
      clr_d   = clr_q;
      done_d  = 1'b0;
    end
  end

  assign busy_o = (state_q != IDLE);
  assign done_o = done_q;

endmodule

// File: tb/tb_tpu_array_ctrl.sv
// Randomized bench for tpu_array_ctrl against a cycle-schedule reference model.
module tb_tpu_array_ctrl;
  import tpu_pkg::*;

  localparam int DIM  = 8;
  localparam int IDXW = 3;

  logic            clk = 1'b0;
  logic            rst_n = 1'b1;
  logic            start_i = 1'b0;
  logic            load_c_i = 1'b0;
  logic            abort_i = 1'b0;
  logic            stall_i = 1'b0;
  logic            out_ready_i = 1'b0;
  logic            busy_o, done_o, mac_en_o, c_clear_o, feed_valid_o, out_valid_o;
  logic [DIM-1:0]  c_wr_en_o;
  logic [IDXW-1:0] k_idx_o, out_row_o;

  always #5 clk = ~clk;

  tpu_array_ctrl #(.DIM(DIM)) dut (
    .clk(clk), .rst_n(rst_n), .start_i(start_i), .load_c_i(load_c_i),
    .abort_i(abort_i), .stall_i(stall_i), .out_ready_i(out_ready_i),
    .busy_o(busy_o), .done_o(done_o), .mac_en_o(mac_en_o), .c_wr_en_o(c_wr_en_o),
    .c_clear_o(c_clear_o), .feed_valid_o(feed_valid_o), .k_idx_o(k_idx_o),
    .out_valid_o(out_valid_o), .out_row_o(out_row_o)
  );

  typedef struct packed {
    logic            busy;
    logic            done;
    logic            mac_en;
    logic [DIM-1:0]  wr;
    logic            clear;
    logic            feed;
    logic [IDXW-1:0] k;
    logic            ov;
    logic [IDXW-1:0] row;
  } obs_t;

  typedef struct {
    logic start, load_c, stall, ready;
    obs_t want;
  } cyc_t;

  cyc_t sched[$];
  int   vectors = 0;
  int   miscompares = 0;
  int   done_at;
  int   done_cnt;

  function automatic obs_t observe();
    return {busy_o, done_o, mac_en_o, c_wr_en_o, c_clear_o, feed_valid_o,
            k_idx_o, out_valid_o, out_row_o};
  endfunction

  // Inputs the DUT must ignore in the given cycle are randomized.
  function automatic cyc_t noise();
    cyc_t c;
    c.start  = 1'($urandom_range(1));
    c.load_c = 1'($urandom_range(1));
    c.stall  = 1'($urandom_range(1));
    c.ready  = 1'($urandom_range(1));
    c.want   = '0;
    return c;
  endfunction

  // Expected per-cycle trace of one command, built from the phase schedule.
  task automatic add_run(input bit load_c, input bit b2b,
                         input int stall_beat, input int stall_len,
                         input int rdy_row, input int rdy_len,
                         input int stall_pct, input int nrdy_pct);
    cyc_t c;
    logic [DIM-1:0] one = DIM'(1);
    int n;
    if (b2b && sched.size() > 0) begin
      c = sched.pop_back();
      c.start  = 1'b1;
      c.load_c = load_c;
      sched.push_back(c);
    end else begin
      c = noise();
      c.start  = 1'b1;
      c.load_c = load_c;
      sched.push_back(c);
    end
    for (int r = 0; r < DIM; r++) begin
      c = noise();
      c.want.busy  = 1'b1;
      c.want.wr    = one << r;
      c.want.clear = !load_c;
      sched.push_back(c);
    end
    for (int j = 0; j <= 3 * DIM - 3; j++) begin
      n = (j == stall_beat) ? stall_len : 0;
      if (int'($urandom_range(99)) < stall_pct) n += $urandom_range(1, 3);
      for (int s = 0; s < n; s++) begin
        c = noise();
        c.stall     = 1'b1;
        c.want.busy = 1'b1;
        c.want.k    = (j < DIM) ? IDXW'(j) : '0;
        sched.push_back(c);
      end
      c = noise();
      c.stall       = 1'b0;
      c.want.busy   = 1'b1;
      c.want.mac_en = 1'b1;
      c.want.feed   = (j < DIM);
      c.want.k      = (j < DIM) ? IDXW'(j) : '0;
      sched.push_back(c);
    end
    for (int r = 0; r < DIM; r++) begin
      n = (r == rdy_row) ? rdy_len : 0;
      if (int'($urandom_range(99)) < nrdy_pct) n += $urandom_range(1, 3);
      for (int s = 0; s <= n; s++) begin
        c = noise();
        c.ready     = (s == n);
        c.want.busy = 1'b1;
        c.want.ov   = 1'b1;
        c.want.row  = IDXW'(r);
        sched.push_back(c);
      end
    end
    c = noise();
    c.start     = 1'b0;
    c.want.done = 1'b1;
    sched.push_back(c);
  endtask

  task automatic run_queue(input string name);
    cyc_t c;
    obs_t o;
    int   i = 0;
    done_at  = -1;
    done_cnt = 0;
    while (sched.size() > 0) begin
      c = sched.pop_front();
      @(posedge clk);
      #1;
      start_i     = c.start;
      load_c_i    = c.load_c;
      stall_i     = c.stall;
      out_ready_i = c.ready;
      abort_i     = 1'b0;
      #1;
      o = observe();
      vectors++;
      if (o !== c.want) begin
        miscompares++;
        $display("FAIL %s cycle=%0d got=%h want=%h", name, i, o, c.want);
      end
      if (o.done === 1'b1) begin
        done_cnt++;
        if (done_at < 0) done_at = i;
      end
      i++;
    end
    @(posedge clk);
    #1;
    start_i = 1'b0; stall_i = 1'b0; out_ready_i = 1'b0;
  endtask

  task automatic check_done_at(input string name, input int want);
    vectors++;
    if (done_at != want) begin
      miscompares++;
      $display("FAIL %s done_cycle got=%0d want=%0d", name, done_at, want);
    end
  endtask

  task automatic check_idle(input string name);
    obs_t o;
    o = observe();
    vectors++;
    if (o !== obs_t'(0)) begin
      miscompares++;
      $display("FAIL %s got=%h want=0", name, o);
    end
  endtask

  task automatic test_reset();
    #1 rst_n = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      start_i = 1'b1; stall_i = 1'($urandom_range(1)); out_ready_i = 1'b1;
      #1 check_idle("reset_hold");
    end
    @(posedge clk);
    #1;
    start_i = 1'b0; stall_i = 1'b0; out_ready_i = 1'b0;
    rst_n = 1'b1;
    #1 check_idle("reset_release");
  endtask

  task automatic test_nominal();
    add_run(1'b1, 1'b0, -1, 0, -1, 0, 0, 0);
    run_queue("nominal");
    check_done_at("nominal", 5 * DIM - 1);
  endtask

  task automatic test_clear();
    add_run(1'b0, 1'b0, -1, 0, -1, 0, 0, 0);
    run_queue("clear");
    check_done_at("clear", 39);
  endtask

  task automatic test_stall();
    add_run(1'b1, 1'b0, 4, 3, -1, 0, 0, 0);
    run_queue("stall");
    check_done_at("stall", 42);
  endtask

  task automatic test_backpressure();
    add_run(1'b1, 1'b0, -1, 0, 5, 2, 0, 0);
    run_queue("backpressure");
    check_done_at("backpressure", 41);
  endtask

  task automatic test_back_to_back();
    int runs = 6;
    for (int r = 0; r < runs; r++)
      add_run(1'($urandom_range(1)), 1'($urandom_range(1)), -1, 0, -1, 0, 30, 30);
    run_queue("random");
    vectors++;
    if (done_cnt != runs) begin
      miscompares++;
      $display("FAIL random done_count got=%0d want=%0d", done_cnt, runs);
    end
  endtask

  task automatic test_abort();
    @(posedge clk);
    #1 start_i = 1'b1; load_c_i = 1'b1; out_ready_i = 1'b1;
    for (int i = 1; i <= 19; i++) begin
      @(posedge clk);
      #1 start_i = 1'b0;
    end
    #1;
    vectors++;
    if ({busy_o, mac_en_o, feed_valid_o, k_idx_o} !== {1'b1, 1'b1, 1'b0, 3'd0}) begin
      miscompares++;
      $display("FAIL abort_pre got=%b%b%b k=%0d want=110 k=0",
               busy_o, mac_en_o, feed_valid_o, k_idx_o);
    end
    abort_i = 1'b1;
    @(posedge clk);
    #1 abort_i = 1'b0;
    #1 check_idle("abort_next");
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #2 check_idle("abort_quiet");
    end
    add_run(1'b1, 1'b0, -1, 0, -1, 0, 0, 0);
    run_queue("after_abort");
    check_done_at("after_abort", 39);
  endtask

  task automatic test_async_reset();
    @(posedge clk);
    #1 start_i = 1'b1; load_c_i = 1'b0; out_ready_i = 1'b1;
    for (int i = 1; i <= 33; i++) begin
      @(posedge clk);
      #1 start_i = 1'b0;
    end
    #1;
    vectors++;
    if ({out_valid_o, out_row_o} !== {1'b1, 3'd2}) begin
      miscompares++;
      $display("FAIL drain_pre got=%b row=%0d want=1 row=2", out_valid_o, out_row_o);
    end
    #1 rst_n = 1'b0;
    #1 check_idle("async_reset");
    @(posedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #2 check_idle("post_reset");
    end
    add_run(1'b1, 1'b0, -1, 0, -1, 0, 0, 0);
    run_queue("after_reset");
    check_done_at("after_reset", 39);
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_clear();
    test_stall();
    test_backpressure();
    test_back_to_back();
    test_abort();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
